alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Sequential issue/writeback stage sitting directly upstream of the 16-bit ALU.
- Holds an 8x16 register file and accepts ALU commands over a valid/ready handshake.
- Drives registered operands and controls (A, B, Select, Mode, cin) into the combinational ALU, captures F/cout/isEqual, and writes the result back to the destination register.
- Maintains a flag register so multi-word arithmetic can chain the ALU's active-low carry.

Parameters:
- NREGS, 8, number of registers; power of two.
- AW, 3, register address width; must equal log2(NREGS).
- W, 16, datapath width; fixed at 16 to match the ALU.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  stage can accept a command.
- cmd_mode  input  1  ALU Mode (1 = logic, 0 = arithmetic).
- cmd_select  input  4  ALU Select.
- cmd_cin  input  1  ALU cin (active-low carry convention).
- cmd_usec  input  1  1 = use flag_c as ALU cin instead of cmd_cin.
- cmd_rs1, cmd_rs2, cmd_rd  input  AW each  source A, source B, destination.
- wr_en  input  1  host register write.
- wr_addr  input  AW  host write address.
- wr_data  input  W  host write data.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  W  combinational read of regfile[dbg_addr].
- alu_a, alu_b  output  W  registered ALU operands.
- alu_select  output  4  registered Select.
- alu_mode  output  1  registered Mode.
- alu_cin  output  1  registered cin.
- alu_f  input  W  ALU result.
- alu_cout  input  1  ALU cout.
- alu_eq  input  1  ALU isEqual.
- done  output  1  one-cycle pulse when writeback occurs.
- result  output  W  last written-back result.
- flag_c, flag_z, flag_e  output  1 each  raw alu_cout (active-low carry), result==0, isEqual.

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE; all registers=0; alu_a/alu_b/alu_select/alu_mode=0; alu_cin=1; result=0.
  - flag_c=1 (no carry); flag_z=0; flag_e=0; done=0.
  - Reset mid-operation aborts the command: no writeback, no done.
- FSM IDLE -> EXEC -> WB -> IDLE:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge N:
    - alu_a<=reg[rs1], alu_b<=reg[rs2], alu_select/alu_mode latched.
    - alu_cin<=(cmd_usec ? flag_c : cmd_cin); rd latched.
    - Go to EXEC.
  - EXEC (cycle N+1): cmd_ready=0; ALU settles. At edge N+1 capture alu_f, alu_cout, alu_eq into holding registers; go to WB.
  - WB (cycle N+2): cmd_ready=0; done=1 for exactly this cycle. At edge N+2:
    - reg[rd]<=captured F; result<=F.
    - flag_c<=cout; flag_z<=(F==0); flag_e<=eq.
    - Go to IDLE.
- Throughput: one command per 3 cycles; cmd_ready is never asserted outside IDLE.
- Operand read uses register contents at the accept edge. A host write in the same cycle is not forwarded.
- Host write (wr_en) applies in any state at the edge.
  - Same edge and same address as the WB write: host write wins.
  - Host write to rs1/rs2 after accept does not affect in-flight operands.
- cmd_rd may equal rs1/rs2; the old value is used as the operand.
- Outputs alu_* hold their values until the next accept.
- dbg_data reflects register state after the last edge.

Test Plan:
- Reset, then host writes R1=0x1234, R2=0x0F0F; cmd mode=0 sel=9 cin=1 rs1=1 rs2=2 rd=3 -> done 2 cycles after accept, R3=0x2143, flag_c=1, flag_z=0.
- R4=0xFFFF, R5=0x0001; add (mode=0 sel=9 cin=1) rd=6 -> R6=0x0000, flag_c=0, flag_z=1. Then R0=0 + R0 with cmd_usec=1 rd=7 -> alu_cin=0, R7=0x0001, flag_c=1.
- Logic: R1=0x00FF, R2=0x0F0F, mode=1 sel=6 rd=3 -> R3=0x0FF0, flag_e=0. Repeat with rs1=rs2=1 -> flag_e=1, R3=0x0000, flag_z=1.
- cmd_valid held high for back-to-back commands -> cmd_ready low in EXEC/WB, second command accepted exactly 3 cycles after the first, both writebacks correct.
- Host wr_en to rd in the WB cycle with wr_data=0xBEEF -> reg[rd]=0xBEEF; result and flags still reflect the ALU output.
- rst asserted during EXEC -> next cycle state IDLE, no done pulse, rd unchanged (0 after reset), cmd_ready=1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Issue/writeback stage in front of a combinational 16-bit ALU.
// It holds an NREGS x W register file and accepts one command per three cycles
// over a valid/ready handshake. Operands and controls are registered into the
// ALU. The F/cout/isEqual results are captured one cycle later and written back
// on the cycle after that.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_mode/select/cin/usec ALU controls; usec chains flag_c into cin
//   cmd_rs1/rs2/rd           source A, source B, destination register
//   wr_en/wr_addr/wr_data    host register write (wins over writeback)
//   dbg_addr/dbg_data        combinational register file read
//   alu_a/b/select/mode/cin  registered ALU inputs
//   alu_f/alu_cout/alu_eq    ALU outputs
//   done, result             writeback pulse and last written-back value
//   flag_c/flag_z/flag_e     raw active-low carry, zero, isEqual
//
// state | meaning
// IDLE  | ready for a command; accept latches operands and controls
// EXEC  | ALU settling; its outputs are captured at the end of the cycle
// WB    | done pulse; result and flags are written at the end of the cycle
module alu_issue_stage #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_mode,
    input  logic [3:0]    cmd_select,
    input  logic          cmd_cin,
    input  logic          cmd_usec,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [AW-1:0] cmd_rd,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_select,
    output logic          alu_mode,
    output logic          alu_cin,
    input  logic [W-1:0]  alu_f,
    input  logic          alu_cout,
    input  logic          alu_eq,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          flag_c,
    output logic          flag_z,
    output logic          flag_e
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_accept;

    logic [W-1:0]    r_regs [NREGS];
    logic [AW-1:0]   r_rd;
    logic [W-1:0]    r_f;
    logic            r_cout;
    logic            r_eq;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next_state = EXEC;
            end
            EXEC: w_next_state = WB;
            WB: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_accept = cmd_valid && cmd_ready;
    assign dbg_data = r_regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_rd       <= '0;
            r_f        <= '0;
            r_cout     <= 1'b1;
            r_eq       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            alu_mode   <= 1'b0;
            alu_cin    <= 1'b1;
            result     <= '0;
            flag_c     <= 1'b1;
            flag_z     <= 1'b0;
            flag_e     <= 1'b0;
        end else begin
            if (w_accept) begin
                alu_a      <= r_regs[cmd_rs1];
                alu_b      <= r_regs[cmd_rs2];
                alu_select <= cmd_select;
                alu_mode   <= cmd_mode;
                alu_cin    <= cmd_usec ? flag_c : cmd_cin;
                r_rd       <= cmd_rd;
            end
            if (r_state == EXEC) begin
                r_f    <= alu_f;
                r_cout <= alu_cout;
                r_eq   <= alu_eq;
            end
            if (r_state == WB) begin
                r_regs[r_rd] <= r_f;
                result       <= r_f;
                flag_c       <= r_cout;
                flag_z       <= (r_f == '0);
                flag_e       <= r_eq;
            end
            // Placed after the writeback so a same-address host write takes precedence.
            if (wr_en) r_regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [3:0]  cmd_select;
    logic        cmd_cin;
    logic        cmd_usec;
    logic [2:0]  cmd_rs1, cmd_rs2, cmd_rd;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_select;
    logic        alu_mode, alu_cin;
    logic [15:0] alu_f;
    logic        alu_cout, alu_eq;
    logic        done;
    logic [15:0] result;
    logic        flag_c, flag_z, flag_e;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_select(cmd_select), .cmd_cin(cmd_cin), .cmd_usec(cmd_usec),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_mode(alu_mode), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_eq(alu_eq),
        .done(done), .result(result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_e(flag_e)
    );

    // Minimal ALU: A plus B (mode 0, sel 9) with active-low carries, XOR (mode 1, sel 6).
    logic [16:0] sum;
    always_comb begin
        sum      = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, ~alu_cin};
        alu_f    = 16'h0000;
        alu_cout = 1'b1;
        alu_eq   = (alu_a == alu_b);
        if (!alu_mode && alu_select == 4'd9) begin
            alu_f    = sum[15:0];
            alu_cout = ~sum[16];
        end else if (alu_mode && alu_select == 4'd6) begin
            alu_f = alu_a ^ alu_b;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Called and returns just after a negedge.
    task automatic hwrite(input logic [2:0] addr, input logic [15:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(posedge clk); @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic issue(input string tag, input logic mode, input logic [3:0] sel,
                         input logic cin, input logic usec, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [2:0] rd, input logic exp_cin);
        cmd_valid = 1'b1; cmd_mode = mode; cmd_select = sel; cmd_cin = cin;
        cmd_usec = usec; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
        chk({tag, "_ready_idle"}, {15'd0, cmd_ready}, 16'd1);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, "_ready_exec"}, {15'd0, cmd_ready}, 16'd0);
        chk({tag, "_done_exec"}, {15'd0, done}, 16'd0);
        chk({tag, "_alu_cin"}, {15'd0, alu_cin}, {15'd0, exp_cin});
        @(posedge clk); @(negedge clk);
        chk({tag, "_done_wb"}, {15'd0, done}, 16'd1);
        @(posedge clk); @(negedge clk);
        chk({tag, "_done_after"}, {15'd0, done}, 16'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_select = 4'd0; cmd_cin = 1'b1;
        cmd_usec = 1'b0; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0; cmd_rd = 3'd0;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'd0; dbg_addr = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {15'd0, cmd_ready}, 16'd1);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_alu_cin", {15'd0, alu_cin}, 16'd1);
        chk("rst_alu_a", alu_a, 16'h0000);
        chk("rst_result", result, 16'h0000);
        chk("rst_flags", {13'd0, flag_c, flag_z, flag_e}, 16'b100);
        rst = 1'b0;

        // Add without carry
        hwrite(3'd1, 16'h1234);
        hwrite(3'd2, 16'h0F0F);
        issue("add1", 1'b0, 4'd9, 1'b1, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1);
        rd_chk("add1_r3", 3'd3, 16'h2143);
        chk("add1_result", result, 16'h2143);
        chk("add1_flags", {14'd0, flag_c, flag_z}, 16'b10);

        // Add producing carry and zero, then chain carry via usec
        hwrite(3'd4, 16'hFFFF);
        hwrite(3'd5, 16'h0001);
        issue("add2", 1'b0, 4'd9, 1'b1, 1'b0, 3'd4, 3'd5, 3'd6, 1'b1);
        rd_chk("add2_r6", 3'd6, 16'h0000);
        chk("add2_flags", {14'd0, flag_c, flag_z}, 16'b01);
        issue("usec", 1'b0, 4'd9, 1'b1, 1'b1, 3'd0, 3'd0, 3'd7, 1'b0);
        rd_chk("usec_r7", 3'd7, 16'h0001);
        chk("usec_flags", {14'd0, flag_c, flag_z}, 16'b10);

        // Logic XOR, unequal then equal operands
        hwrite(3'd1, 16'h00FF);
        hwrite(3'd2, 16'h0F0F);
        issue("xor1", 1'b1, 4'd6, 1'b1, 1'b0, 3'd1, 3'd2, 3'd3, 1'b1);
        rd_chk("xor1_r3", 3'd3, 16'h0FF0);
        chk("xor1_flags", {14'd0, flag_z, flag_e}, 16'b00);
        issue("xor2", 1'b1, 4'd6, 1'b1, 1'b0, 3'd1, 3'd1, 3'd3, 1'b1);
        rd_chk("xor2_r3", 3'd3, 16'h0000);
        chk("xor2_flags", {14'd0, flag_z, flag_e}, 16'b11);

        // Back-to-back with cmd_valid held high; second reads R4 written by the first
        hwrite(3'd1, 16'h0001);
        hwrite(3'd2, 16'h0002);
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_select = 4'd9; cmd_cin = 1'b1; cmd_usec = 1'b0;
        cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd4;
        chk("b2b_ready0", {15'd0, cmd_ready}, 16'd1);
        @(posedge clk); @(negedge clk);
        cmd_rs1 = 3'd4; cmd_rs2 = 3'd4; cmd_rd = 3'd5;
        chk("b2b_ready_exec", {15'd0, cmd_ready}, 16'd0);
        @(posedge clk); @(negedge clk);
        chk("b2b_ready_wb", {15'd0, cmd_ready}, 16'd0);
        chk("b2b_done1", {15'd0, done}, 16'd1);
        @(posedge clk); @(negedge clk);
        chk("b2b_ready3", {15'd0, cmd_ready}, 16'd1);
        rd_chk("b2b_r4", 3'd4, 16'h0003);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_ready_exec2", {15'd0, cmd_ready}, 16'd0);
        chk("b2b_alu_a2", alu_a, 16'h0003);
        @(posedge clk); @(negedge clk);
        chk("b2b_done2", {15'd0, done}, 16'd1);
        @(posedge clk); @(negedge clk);
        rd_chk("b2b_r5", 3'd5, 16'h0006);

        // Host write to rd during WB wins over writeback
        cmd_valid = 1'b1; cmd_rs1 = 3'd1; cmd_rs2 = 3'd1; cmd_rd = 3'd2;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("hw_done", {15'd0, done}, 16'd1);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF;
        @(posedge clk); @(negedge clk);
        wr_en = 1'b0;
        rd_chk("hw_r2", 3'd2, 16'hBEEF);
        chk("hw_result", result, 16'h0002);
        chk("hw_flags", {14'd0, flag_c, flag_z}, 16'b10);

        // Reset during EXEC aborts the command
        cmd_valid = 1'b1; cmd_rs1 = 3'd1; cmd_rs2 = 3'd1; cmd_rd = 3'd6;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {15'd0, cmd_ready}, 16'd1);
        chk("abort_done0", {15'd0, done}, 16'd0);
        @(posedge clk); @(negedge clk);
        chk("abort_done1", {15'd0, done}, 16'd0);
        rd_chk("abort_r6", 3'd6, 16'h0000);
        chk("abort_result", result, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
